// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: resolves forwarded operands, detects load-use and applies flush/stall/bubble.
// Optional build macro WB_BYPASS_EN adds a WB-stage bypass for a register file without write-before-read.
module id_exe_stage_reg #(
   parameter int XLEN      = 32,
   parameter int CTRL_W    = 16,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ID_valid,
   input  logic [XLEN-1:0]      ID_pc,
   input  logic [XLEN-1:0]      ID_imm,
   input  logic [CTRL_W-1:0]    ID_ctrl,
   input  logic [REGADDR_W-1:0] ID_rs1_addr,
   input  logic [REGADDR_W-1:0] ID_rs2_addr,
   input  logic [REGADDR_W-1:0] ID_rd_addr,
   input  logic [XLEN-1:0]      ID_rs1_data,
   input  logic [XLEN-1:0]      ID_rs2_data,
   input  logic [1:0]           Forwarding_rs1_src,
   input  logic [1:0]           Forwarding_rs2_src,
   input  logic [XLEN-1:0]      EXE_result,
   input  logic                 EXE_MemRead,
   input  logic [REGADDR_W-1:0] EXE_rd_addr,
   input  logic [XLEN-1:0]      MEM_result,
`ifdef WB_BYPASS_EN
   input  logic                 WB_RegWrite,
   input  logic [REGADDR_W-1:0] WB_rd_addr,
   input  logic [XLEN-1:0]      WB_result,
`endif
   input  logic                 mem_stall,
   input  logic                 flush,
   output logic                 hazard_stall,
   output logic                 EXE_valid,
   output logic [XLEN-1:0]      EXE_pc,
   output logic [XLEN-1:0]      EXE_imm,
   output logic [CTRL_W-1:0]    EXE_ctrl,
   output logic [XLEN-1:0]      EXE_rs1_val,
   output logic [XLEN-1:0]      EXE_rs2_val,
   output logic [REGADDR_W-1:0] EXE_rs1_addr,
   output logic [REGADDR_W-1:0] EXE_rs2_addr,
   output logic [REGADDR_W-1:0] EXE_rd
);

   logic [XLEN-1:0]      rs1_rf, rs2_rf, rs1_fwd, rs2_fwd;
   logic                 load_use;

   logic                 valid_q, valid_d;
   logic [XLEN-1:0]      pc_q, pc_d, imm_q, imm_d;
   logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
   logic [XLEN-1:0]      rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
   logic [REGADDR_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;

`ifdef WB_BYPASS_EN
   // x0 is excluded later by the operand guard, so the rs!=0 term is implicit here.
   assign rs1_rf = (WB_RegWrite && (WB_rd_addr == ID_rs1_addr)) ? WB_result : ID_rs1_data;
   assign rs2_rf = (WB_RegWrite && (WB_rd_addr == ID_rs2_addr)) ? WB_result : ID_rs2_data;
`else
   assign rs1_rf = ID_rs1_data;
   assign rs2_rf = ID_rs2_data;
`endif

   function automatic logic [XLEN-1:0] resolve(input logic [REGADDR_W-1:0] addr,
                                               input logic [1:0]           src,
                                               input logic [XLEN-1:0]      rf);
      logic [XLEN-1:0] val;
      if (addr == '0) begin
         val = '0;
      end else begin
         case (src)
            2'b01:   val = EXE_result;
            2'b10:   val = MEM_result;
            default: val = rf;
         endcase
      end
      return val;
   endfunction

   assign rs1_fwd = resolve(ID_rs1_addr, Forwarding_rs1_src, rs1_rf);
   assign rs2_fwd = resolve(ID_rs2_addr, Forwarding_rs2_src, rs2_rf);

   // Both rs fields are compared regardless of format; a spurious match only costs a bubble.
   assign load_use = ID_valid && EXE_MemRead && (EXE_rd_addr != '0) &&
                     ((EXE_rd_addr == ID_rs1_addr) || (EXE_rd_addr == ID_rs2_addr));

   assign hazard_stall = rst && load_use && !flush && !mem_stall;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      ctrl_d     = ctrl_q;
      rs1_val_d  = rs1_val_q;
      rs2_val_d  = rs2_val_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_d       = rd_q;
      if (!mem_stall) begin
         if (flush || load_use) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            imm_d      = '0;
            ctrl_d     = '0;
            rs1_val_d  = '0;
            rs2_val_d  = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_d       = '0;
         end else begin
            valid_d    = ID_valid;
            pc_d       = ID_pc;
            imm_d      = ID_imm;
            ctrl_d     = ID_valid ? ID_ctrl : '0;
            rs1_val_d  = rs1_fwd;
            rs2_val_d  = rs2_fwd;
            rs1_addr_d = ID_rs1_addr;
            rs2_addr_d = ID_rs2_addr;
            rd_d       = ID_rd_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         imm_q      <= '0;
         ctrl_q     <= '0;
         rs1_val_q  <= '0;
         rs2_val_q  <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_q       <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         ctrl_q     <= ctrl_d;
         rs1_val_q  <= rs1_val_d;
         rs2_val_q  <= rs2_val_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_q       <= rd_d;
      end
   end

   assign EXE_valid    = valid_q;
   assign EXE_pc       = pc_q;
   assign EXE_imm      = imm_q;
   assign EXE_ctrl     = ctrl_q;
   assign EXE_rs1_val  = rs1_val_q;
   assign EXE_rs2_val  = rs2_val_q;
   assign EXE_rs1_addr = rs1_addr_q;
   assign EXE_rs2_addr = rs2_addr_q;
   assign EXE_rd       = rd_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed + random bench for id_exe_stage_reg with an expected-bundle queue and a reference model.
module tb_id_exe_stage_reg;

   localparam int XLEN = 32;
   localparam int CTRL_W = 16;
   localparam int RA = 5;
   localparam int W = 1 + 4*XLEN + CTRL_W + 3*RA;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            ID_valid;
   logic [XLEN-1:0] ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
   logic [CTRL_W-1:0] ID_ctrl;
   logic [RA-1:0]   ID_rs1_addr, ID_rs2_addr, ID_rd_addr, EXE_rd_addr;
   logic [1:0]      Forwarding_rs1_src, Forwarding_rs2_src;
   logic [XLEN-1:0] EXE_result, MEM_result;
   logic            EXE_MemRead, mem_stall, flush;
   logic            hazard_stall, EXE_valid;
   logic [XLEN-1:0] EXE_pc, EXE_imm, EXE_rs1_val, EXE_rs2_val;
   logic [CTRL_W-1:0] EXE_ctrl;
   logic [RA-1:0]   EXE_rs1_addr, EXE_rs2_addr, EXE_rd;
`ifdef WB_BYPASS_EN
   logic            WB_RegWrite = 1'b0;
   logic [RA-1:0]   WB_rd_addr = '0;
   logic [XLEN-1:0] WB_result = '0;
`endif

   id_exe_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .REGADDR_W(RA)) dut (
      .clk(clk), .rst(rst),
      .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_imm(ID_imm), .ID_ctrl(ID_ctrl),
      .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr), .ID_rd_addr(ID_rd_addr),
      .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data),
      .Forwarding_rs1_src(Forwarding_rs1_src), .Forwarding_rs2_src(Forwarding_rs2_src),
      .EXE_result(EXE_result), .EXE_MemRead(EXE_MemRead), .EXE_rd_addr(EXE_rd_addr),
      .MEM_result(MEM_result),
`ifdef WB_BYPASS_EN
      .WB_RegWrite(WB_RegWrite), .WB_rd_addr(WB_rd_addr), .WB_result(WB_result),
`endif
      .mem_stall(mem_stall), .flush(flush), .hazard_stall(hazard_stall),
      .EXE_valid(EXE_valid), .EXE_pc(EXE_pc), .EXE_imm(EXE_imm), .EXE_ctrl(EXE_ctrl),
      .EXE_rs1_val(EXE_rs1_val), .EXE_rs2_val(EXE_rs2_val),
      .EXE_rs1_addr(EXE_rs1_addr), .EXE_rs2_addr(EXE_rs2_addr), .EXE_rd(EXE_rd)
   );

   // Scoreboard
   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_q = '0;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] obs_bundle();
      return {EXE_valid, EXE_pc, EXE_imm, EXE_ctrl, EXE_rs1_val, EXE_rs2_val,
              EXE_rs1_addr, EXE_rs2_addr, EXE_rd};
   endfunction

   function automatic logic [XLEN-1:0] ref_opnd(input logic [RA-1:0] a, input logic [1:0] s,
                                                input logic [XLEN-1:0] rf);
      if (a == 0) return '0;
      if (s == 2'b01) return EXE_result;
      if (s == 2'b10) return MEM_result;
      return rf;
   endfunction

   // One clock: check hazard_stall before the edge, predict the register bundle, compare after.
   task automatic cycle(input string tag);
      logic use_m;
      logic [W-1:0] nxt;
      @(negedge clk);
      use_m = ID_valid && EXE_MemRead && (EXE_rd_addr != 0) &&
              (EXE_rd_addr == ID_rs1_addr || EXE_rd_addr == ID_rs2_addr);
      chk({tag, "_hz"}, W'(hazard_stall), W'(use_m && !flush && !mem_stall));
      if (mem_stall) nxt = model_q;
      else if (flush || use_m) nxt = '0;
      else nxt = {ID_valid, ID_pc, ID_imm, (ID_valid ? ID_ctrl : 16'h0),
                  ref_opnd(ID_rs1_addr, Forwarding_rs1_src, ID_rs1_data),
                  ref_opnd(ID_rs2_addr, Forwarding_rs2_src, ID_rs2_data),
                  ID_rs1_addr, ID_rs2_addr, ID_rd_addr};
      exp_q.push_back(nxt);
      model_q = nxt;
      @(posedge clk);
      #1;
      chk(tag, obs_bundle(), exp_q.pop_front());
   endtask

   // Driver tasks
   task automatic drive_idle();
      ID_valid = 1'b0; ID_pc = '0; ID_imm = '0; ID_ctrl = '0;
      ID_rs1_addr = '0; ID_rs2_addr = '0; ID_rd_addr = '0;
      ID_rs1_data = '0; ID_rs2_data = '0;
      Forwarding_rs1_src = 2'b00; Forwarding_rs2_src = 2'b00;
      EXE_result = '0; MEM_result = '0; EXE_MemRead = 1'b0; EXE_rd_addr = '0;
      mem_stall = 1'b0; flush = 1'b0;
   endtask

   task automatic drive_instr(input logic [XLEN-1:0] pc, input logic [RA-1:0] rs1,
                              input logic [RA-1:0] rs2, input logic [RA-1:0] rd);
      ID_valid = 1'b1; ID_pc = pc; ID_imm = pc ^ 32'h0F0F_0F0F; ID_ctrl = 16'h0003;
      ID_rs1_addr = rs1; ID_rs2_addr = rs2; ID_rd_addr = rd;
      ID_rs1_data = 32'h1000_0000 | pc; ID_rs2_data = 32'h2000_0000 | pc;
      Forwarding_rs1_src = 2'b00; Forwarding_rs2_src = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      // Reset held with a load-use pattern present: outputs and hazard_stall stay 0.
      ID_valid = 1'b1; EXE_MemRead = 1'b1; EXE_rd_addr = 5'd4; ID_rs1_addr = 5'd4;
      #1;
      chk("reset_regs", obs_bundle(), '0);
      chk("reset_hz", W'(hazard_stall), '0);
      @(posedge clk); #1;
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b1;

      // Forwarding selects
      drive_instr(32'h0000_0040, 5'd5, 5'd6, 5'd1);
      Forwarding_rs1_src = 2'b01; EXE_result = 32'hDEAD_BEEF;
      Forwarding_rs2_src = 2'b10; MEM_result = 32'h1234_5678;
      cycle("fwd");
      chk("fwd_rs1", W'(EXE_rs1_val), W'(32'hDEAD_BEEF));
      chk("fwd_rs2", W'(EXE_rs2_val), W'(32'h1234_5678));

      // x0 guard and reserved select 11
      drive_instr(32'h0000_0044, 5'd0, 5'd3, 5'd2);
      Forwarding_rs1_src = 2'b01; EXE_result = 32'hFFFF_FFFF;
      Forwarding_rs2_src = 2'b11; ID_rs2_data = 32'h0000_0033; MEM_result = 32'h5555_5555;
      cycle("x0");
      chk("x0_rs1", W'(EXE_rs1_val), '0);
      chk("sel11_rs2", W'(EXE_rs2_val), W'(32'h0000_0033));

      // Load-use: one bubble, then issue with MEM-forwarded load data
      drive_instr(32'h0000_0048, 5'd2, 5'd7, 5'd8);
      EXE_MemRead = 1'b1; EXE_rd_addr = 5'd7;
      cycle("lu_bubble");
      chk("lu_valid0", W'(EXE_valid), '0);
      EXE_MemRead = 1'b0; EXE_rd_addr = 5'd0;
      Forwarding_rs2_src = 2'b10; MEM_result = 32'h0000_A5A5;
      cycle("lu_issue");
      chk("lu_rs2", W'(EXE_rs2_val), W'(32'h0000_A5A5));
      chk("lu_valid1", W'(EXE_valid), W'(1'b1));

      // Load writing x0 never stalls
      drive_instr(32'h0000_004C, 5'd0, 5'd0, 5'd9);
      EXE_MemRead = 1'b1; EXE_rd_addr = 5'd0;
      cycle("lu_x0");
      chk("lu_x0_valid", W'(EXE_valid), W'(1'b1));

      // ID_valid=0 must not carry control bits
      drive_instr(32'h0000_0050, 5'd1, 5'd2, 5'd3);
      ID_valid = 1'b0; ID_ctrl = 16'hFFFF; EXE_MemRead = 1'b0;
      cycle("invalid");
      chk("invalid_ctrl", W'(EXE_ctrl), '0);

      // Flush outranks load-use
      drive_instr(32'h0000_0054, 5'd7, 5'd1, 5'd3);
      EXE_MemRead = 1'b1; EXE_rd_addr = 5'd7; flush = 1'b1;
      cycle("flush_use");
      chk("flush_valid", W'(EXE_valid), '0);
      chk("flush_ctrl", W'(EXE_ctrl), '0);

      // mem_stall holds everything, even with flush asserted; flush applies on release
      drive_instr(32'h0000_0100, 5'd1, 5'd2, 5'd3);
      EXE_MemRead = 1'b0; EXE_rd_addr = 5'd0; flush = 1'b0;
      cycle("pre_stall");
      for (int i = 0; i < 3; i++) begin
         drive_instr(32'h0000_0200 + 32'(i*4), 5'd7, 5'd7, 5'd4);
         EXE_MemRead = 1'b1; EXE_rd_addr = 5'd7;
         mem_stall = 1'b1; flush = 1'b1;
         cycle("mstall");
         chk("mstall_pc", W'(EXE_pc), W'(32'h0000_0100));
      end
      mem_stall = 1'b0;
      cycle("mstall_release");
      chk("release_valid", W'(EXE_valid), '0);

      // Randomised traffic against the model
      for (int i = 0; i < 40; i++) begin
         drive_instr($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 31)));
         ID_valid = ($urandom_range(0, 5) != 0);
         ID_ctrl = 16'($urandom);
         ID_rs1_data = $urandom; ID_rs2_data = $urandom;
         Forwarding_rs1_src = 2'($urandom_range(0, 3));
         Forwarding_rs2_src = 2'($urandom_range(0, 3));
         EXE_result = $urandom; MEM_result = $urandom;
         EXE_MemRead = ($urandom_range(0, 2) == 0);
         EXE_rd_addr = 5'($urandom_range(0, 7));
         mem_stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 6) == 0);
         cycle("rand");
      end

      // Mid-run asynchronous reset with a valid bundle registered
      drive_idle();
      drive_instr(32'h0000_0300, 5'd1, 5'd2, 5'd3);
      cycle("pre_rst");
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", obs_bundle(), '0);
      model_q = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      drive_instr(32'h0000_0400, 5'd4, 5'd5, 5'd6);
      cycle("post_rst");
      chk("post_rst_pc", W'(EXE_pc), W'(32'h0000_0400));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
ID/EXE pipeline boundary register, directly downstream of the operand-forwarding select logic in the 5-stage RV32 core.
- Consumes the two 2-bit forwarding selects and resolves each source operand from RF, EXE-result or MEM-result.
- Detects load-use hazards and inserts a single bubble.
- Applies the flush, stall and bubble controls, then registers the instruction bundle for the EXE stage.

Parameters:
XLEN, 32, datapath/operand width
CTRL_W, 16, width of opaque decoded-control bundle passed ID->EXE
REGADDR_W, 5, register address width

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  asynchronous, active-low reset
ID_valid  input  1  ID holds a real instruction
ID_pc  input  XLEN  PC of ID instruction
ID_imm  input  XLEN  decoded immediate
ID_ctrl  input  CTRL_W  decoded control bundle; bit0 = RegWrite, bit1 = MemRead
ID_rs1_addr  input  REGADDR_W  source 1 index
ID_rs2_addr  input  REGADDR_W  source 2 index
ID_rd_addr  input  REGADDR_W  destination index
ID_rs1_data  input  XLEN  RF read data, port 1
ID_rs2_data  input  XLEN  RF read data, port 2
Forwarding_rs1_src  input  2  00 RF, 01 EXE, 10 MEM, 11 reserved->RF
Forwarding_rs2_src  input  2  same encoding
EXE_result  input  XLEN  ALU result currently in EXE
EXE_MemRead  input  1  instruction in EXE is a load
EXE_rd_addr  input  REGADDR_W  rd of EXE instruction
MEM_result  input  XLEN  MEM-stage writeback value (load data or ALU)
mem_stall  input  1  memory wait; freezes whole pipe
flush  input  1  branch/jump redirect from EXE
hazard_stall  output  1  hold PC and IF/ID this cycle
EXE_valid  output  1  registered valid
EXE_pc  output  XLEN  registered PC
EXE_imm  output  XLEN  registered immediate
EXE_ctrl  output  CTRL_W  registered control
EXE_rs1_val  output  XLEN  registered resolved operand 1
EXE_rs2_val  output  XLEN  registered resolved operand 2
EXE_rs1_addr  output  REGADDR_W  registered rs1
EXE_rs2_addr  output  REGADDR_W  registered rs2
EXE_rd  output  REGADDR_W  registered rd

Behaviour:
- Reset (rst=0, async): every output register is 0, EXE_valid=0 and hazard_stall=0. Reset deasserts synchronously into the first clk edge.
- Operand mux (combinational): if rsN_addr==0, the operand is 0 regardless of the select (upstream does not exclude x0). Otherwise the select chooses RF/EXE/MEM; 11 chooses RF.
- Load-use detect (combinational): use = ID_valid & EXE_MemRead & EXE_rd_addr!=0 & (EXE_rd_addr==rs1 | EXE_rd_addr==rs2). This is checked for both rs fields irrespective of instruction format.
- hazard_stall = use & !flush & !mem_stall.
- Register update at each posedge, priority order:
  1. mem_stall=1: all registers hold, including when flush is also asserted. The flush source must hold flush until mem_stall drops.
  2. flush=1: EXE_valid<=0, EXE_ctrl<=0 and other fields don't-care (cleared to 0). hazard_stall is forced 0.
  3. use=1: bubble, identical to a flush. The ID instruction stays put. The next cycle the load is in MEM, upstream selects 10, and the instruction issues with load data.
  4. Otherwise: capture the ID bundle and resolved operands, with EXE_valid<=ID_valid.
- ID_valid=0 loads EXE_valid=0 and EXE_ctrl=0, so a bubble never carries RegWrite=1.
- Latency: exactly 1 cycle from ID inputs to EXE outputs.
- Load-use costs exactly 1 bubble. Back-to-back loads feeding each other each cost 1.

Optional Feature:
WB_BYPASS_EN
- Defined: adds inputs WB_RegWrite (1), WB_rd_addr (REGADDR_W) and WB_result (XLEN).
- When the select is 00 and WB_RegWrite & WB_rd_addr==rsN & rsN!=0, the operand takes WB_result. This supports a register file without write-before-read.
- Undefined: the ports are absent and select 00 always uses RF data.

Test Plan:
1. Reset: rst=0 mid-run with EXE_valid=1 -> all outputs 0 immediately (before any clk edge); first capture happens on the first edge after release.
2. Forward select: rs1=5, src=01, EXE_result=0xDEADBEEF; rs2=6, src=10, MEM_result=0x12345678 -> next cycle EXE_rs1_val=0xDEADBEEF, EXE_rs2_val=0x12345678.
3. x0 guard: rs1=0, src=01, EXE_result=0xFFFFFFFF -> EXE_rs1_val=0.
4. Load-use: EXE_MemRead=1, EXE_rd_addr=7, ID rs2=7:
   - hazard_stall=1 for 1 cycle and EXE_valid=0.
   - Next cycle src=10, MEM_result=0xA5A5 -> EXE_rs2_val=0xA5A5 with EXE_valid=1.
5. Flush vs use: flush=1 with a load-use present -> hazard_stall=0, EXE_valid=0, EXE_ctrl=0.
6. mem_stall=1 for 3 cycles with changing ID inputs and flush=1 -> EXE outputs unchanged; on release, flush takes effect (EXE_valid=0).
